adc_ad7928_reader: RTL and testbench
====================================

Name: adc_ad7928_reader

Overview:
- SPI master that answers the FOC current loop's ADC sample strobe.
- On each `sn_adc` pulse it reads three phase-current channels from an AD7928-style 12-bit 8-channel SAR ADC, using pipelined 16-bit frames.
- When all three results are in, it returns them on `adc_a`/`adc_b`/`adc_c` with a one-cycle `en_adc` pulse.
- Sits between the board ADC pins and the FOC core's `sn_adc`/`en_adc`/`adc_*` interface.

Parameters:
- CLK_DIV, 8'd2, half-period of `spi_sck` in `clk` cycles; legal range 1..255.
- CS_GAP, 8'd2, `clk` cycles `spi_ss` stays high between frames; legal range 1..255.
- CH_A, 3'd0, ADC channel address for phase A.
- CH_B, 3'd1, ADC channel address for phase B.
- CH_C, 3'd2, ADC channel address for phase C.
- RANGE, 1'b0, RANGE bit in the control word.
- CODING, 1'b1, CODING bit in the control word (1 = straight binary).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- sn_adc  in  1  sample request, one-cycle pulse
- en_adc  out  1  result valid, one-cycle pulse
- adc_a  out  12  phase A result
- adc_b  out  12  phase B result
- adc_c  out  12  phase C result
- addr_err  out  1  returned channel address mismatch for the latest result set
- busy  out  1  conversion sequence in progress
- spi_ss  out  1  ADC chip select, active-low
- spi_sck  out  1  SPI clock, idles high
- spi_mosi  out  1  control word to ADC, MSB first
- spi_miso  in  1  ADC data, MSB first

Behaviour:
- Reset values (`rst` high, asynchronous):
  - `spi_ss`=1, `spi_sck`=1, `spi_mosi`=0.
  - `en_adc`=0, `busy`=0, `addr_err`=0.
  - `adc_a`/`adc_b`/`adc_c`=0.
  - FSM to IDLE, all counters cleared.
  - `rst` asserted mid-sequence aborts immediately: the partial frame is discarded and `adc_*` return to 0.
- FSM states: IDLE -> SETUP -> SHIFT -> GAP -> (SETUP for the next frame, or DONE after frame 3) -> IDLE.
- IDLE:
  - `sn_adc`=1 sampled in cycle T0 -> SETUP in T0+1, frame index k=0.
  - `sn_adc` while not IDLE (including the DONE cycle) is ignored; it is neither queued nor flagged.
- SETUP: 1 cycle.
  - `spi_ss`=0, `spi_sck`=1.
  - `spi_mosi` = bit 15 of control word k.
- SHIFT: 16 bits, each 2*CLK_DIV cycles.
  - `spi_sck`=0 for CLK_DIV cycles, then 1 for CLK_DIV cycles.
  - `spi_mosi` changes only in the cycle `spi_sck` goes low (next bit, bits 15..0).
  - `spi_miso` is sampled in the cycle `spi_sck` goes high, and shifted into a 16-bit register MSB first.
  - After the 16th high phase -> GAP.
- GAP:
  - `spi_ss`=1, `spi_sck`=1 for CS_GAP cycles.
  - Then k+1 and SETUP, or DONE if k=3.
- Control word for channel `ch`: {1,0,0,ch[2:0],1,1,0,0,RANGE,CODING,4'b0}.
  - Frame channels: k=0: CH_A; k=1: CH_B; k=2: CH_C; k=3: CH_C (dummy).
- Received word w (ADC pipeline, one frame behind):
  - w[15] is don't-care, w[14:12] is the channel address, w[11:0] is data.
  - Frame 0 is discarded.
  - Frame 1 carries phase A, expected address CH_A.
  - Frame 2 carries phase B, expected address CH_B.
  - Frame 3 carries phase C, expected address CH_C.
- DONE: 1 cycle, then IDLE.
  - `en_adc`=1.
  - `adc_a`/`adc_b`/`adc_c` update in this same cycle and hold until the next DONE.
  - `addr_err` = OR of the three address mismatches; it updates with `en_adc` and holds until the next DONE.
  - Data is delivered even when `addr_err`=1.
- `busy`=1 from T0+1 through the DONE cycle inclusive. A new `sn_adc` is accepted in the cycle after DONE.
- Latency: DONE occurs at T0 + 4*(1+32*CLK_DIV+CS_GAP) + 1.
  - With defaults this is T0+269.
  - Per-frame `spi_ss` low time is 1+32*CLK_DIV cycles.

Test Plan:
- Reset: hold `rst`=1 -> `spi_ss`=1, `spi_sck`=1, `en_adc`=0, `busy`=0, `adc_*`=0, `addr_err`=0. Release; 50 idle cycles -> no SPI activity.
- Nominal (defaults): ADC model returns {0,CH,data} with A=0x123, B=0x456, C=0x789.
  - MOSI words must be 0x8310, 0x8710, 0x8B10, 0x8B10.
  - `en_adc` is a single pulse at T0+269.
  - `adc_a`=0x123, `adc_b`=0x456, `adc_c`=0x789, `addr_err`=0.
  - `spi_ss` low 65 cycles per frame, high 2 cycles between frames.
- Address mismatch: model returns address 3'd5 in frame 2 -> `adc_b` still updated, `addr_err`=1. Next clean sequence -> `addr_err`=0.
- Request while busy: extra `sn_adc` at T0+100 and in the DONE cycle -> exactly one `en_adc`, at T0+269. A pulse at T0+270 starts a new sequence, with `en_adc` at T0+539.
- Reset mid-frame: assert `rst` during frame 2 SHIFT -> same cycle `spi_ss`=1, `spi_sck`=1, `busy`=0, `adc_*`=0. No `en_adc` follows. A fresh `sn_adc` completes normally.
- CLK_DIV=1, CS_GAP=1: `sn_adc` at T0 -> `en_adc` at T0+4*(1+32+1)+1=T0+137. Each `spi_sck` phase lasts 1 cycle; data still correct.

Source files
------------

// File: rtl/adc_ad7928_reader.sv
// ============================================================================
//  Module      : adc_ad7928_reader
//  Description : SPI master that reads three phase-current channels from an
//                AD7928-style 12-bit SAR ADC on every sample strobe. It uses
//                four pipelined 16-bit frames: frame 0 primes the channel
//                pipeline, and frames 1..3 return phases A, B and C.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module adc_ad7928_reader #(
    parameter logic [7:0] CLK_DIV = 8'd2,
    parameter logic [7:0] CS_GAP  = 8'd2,
    parameter logic [2:0] CH_A    = 3'd0,
    parameter logic [2:0] CH_B    = 3'd1,
    parameter logic [2:0] CH_C    = 3'd2,
    parameter logic       RANGE   = 1'b0,
    parameter logic       CODING  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sn_adc,
    output logic        en_adc,
    output logic [11:0] adc_a,
    output logic [11:0] adc_b,
    output logic [11:0] adc_c,
    output logic        addr_err,
    output logic        busy,
    output logic        spi_ss,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SHIFT = 3'd2,
        S_GAP   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Control word: WRITE=1, SEQ=0, ADD3=0, channel, PM=11, SHADOW=0, WEAK=0.
    function automatic logic [15:0] ctrl_word(input logic [2:0] ch);
        return {1'b1, 2'b00, ch, 2'b11, 2'b00, RANGE, CODING, 4'b0000};
    endfunction

    // Frame 3 repeats channel C as a dummy so that C's result is clocked out.
    function automatic logic [2:0] frame_ch(input logic [1:0] k);
        logic [2:0] ch;
        case (k)
            2'd0:    ch = CH_A;
            2'd1:    ch = CH_B;
            default: ch = CH_C;
        endcase
        return ch;
    endfunction

    state_t      r_state;
    logic [7:0]  r_div;
    logic [3:0]  r_bit;
    logic [7:0]  r_gap;
    logic [1:0]  r_frame;
    logic [15:0] r_tx;
    // Only the low 15 received bits are kept; bit 15 of the ADC word is don't-care.
    logic [14:0] r_rx;
    logic [11:0] r_res_a;
    logic [11:0] r_res_b;
    logic        r_err_a;
    logic        r_err_b;

    logic        w_div_end;
    logic        w_gap_end;
    logic [1:0]  w_frame_nxt;
    logic [15:0] w_cw_first;
    logic [15:0] w_cw_next;

    assign w_div_end   = (r_div == (CLK_DIV - 8'd1));
    assign w_gap_end   = (r_gap == (CS_GAP - 8'd1));
    assign w_frame_nxt = r_frame + 2'd1;
    assign w_cw_first  = ctrl_word(CH_A);
    assign w_cw_next   = ctrl_word(frame_ch(w_frame_nxt));

    // Sequencer: frame timing, SPI pin generation, result capture and hand-off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_div    <= 8'd0;
            r_bit    <= 4'd0;
            r_gap    <= 8'd0;
            r_frame  <= 2'd0;
            r_tx     <= 16'd0;
            r_rx     <= 15'd0;
            r_res_a  <= 12'd0;
            r_res_b  <= 12'd0;
            r_err_a  <= 1'b0;
            r_err_b  <= 1'b0;
            en_adc   <= 1'b0;
            adc_a    <= 12'd0;
            adc_b    <= 12'd0;
            adc_c    <= 12'd0;
            addr_err <= 1'b0;
            busy     <= 1'b0;
            spi_ss   <= 1'b1;
            spi_sck  <= 1'b1;
            spi_mosi <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    en_adc <= 1'b0;
                    if (sn_adc) begin
                        r_state  <= S_SETUP;
                        r_frame  <= 2'd0;
                        busy     <= 1'b1;
                        spi_ss   <= 1'b0;
                        spi_sck  <= 1'b1;
                        r_tx     <= w_cw_first;
                        spi_mosi <= w_cw_first[15];
                    end
                end

                S_SETUP: begin
                    r_state <= S_SHIFT;
                    spi_sck <= 1'b0;
                    r_div   <= 8'd0;
                    r_bit   <= 4'd0;
                end

                S_SHIFT: begin
                    // MISO is taken in the first cycle of each high phase.
                    if (spi_sck && (r_div == 8'd0)) begin
                        r_rx <= {r_rx[13:0], spi_miso};
                    end
                    if (w_div_end) begin
                        r_div <= 8'd0;
                        if (!spi_sck) begin
                            spi_sck <= 1'b1;
                        end else if (r_bit == 4'd15) begin
                            r_state <= S_GAP;
                            spi_ss  <= 1'b1;
                            r_gap   <= 8'd0;
                        end else begin
                            spi_sck  <= 1'b0;
                            r_bit    <= r_bit + 4'd1;
                            r_tx     <= {r_tx[14:0], 1'b0};
                            spi_mosi <= r_tx[14];
                        end
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                end

                S_GAP: begin
                    if (w_gap_end) begin
                        // The received word belongs to the previous frame's channel.
                        case (r_frame)
                            2'd1: begin
                                r_res_a <= r_rx[11:0];
                                r_err_a <= (r_rx[14:12] != CH_A);
                            end
                            2'd2: begin
                                r_res_b <= r_rx[11:0];
                                r_err_b <= (r_rx[14:12] != CH_B);
                            end
                            default: begin
                            end
                        endcase
                        if (r_frame == 2'd3) begin
                            r_state  <= S_DONE;
                            en_adc   <= 1'b1;
                            adc_a    <= r_res_a;
                            adc_b    <= r_res_b;
                            adc_c    <= r_rx[11:0];
                            addr_err <= r_err_a | r_err_b | (r_rx[14:12] != CH_C);
                        end else begin
                            r_state  <= S_SETUP;
                            r_frame  <= w_frame_nxt;
                            spi_ss   <= 1'b0;
                            r_tx     <= w_cw_next;
                            spi_mosi <= w_cw_next[15];
                        end
                    end else begin
                        r_gap <= r_gap + 8'd1;
                    end
                end

                S_DONE: begin
                    en_adc  <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_adc_ad7928_reader.sv
// ============================================================================
//  Module      : tb_adc_ad7928_reader
//  Description : Self-checking bench for adc_ad7928_reader. Two instances are
//                used: one with default timing and one with CLK_DIV=1 and
//                CS_GAP=1. An ADC model answers each frame with the channel
//                requested in the previous frame.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_adc_ad7928_reader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]  sn     = 2'b00;
    logic [1:0]  miso_r = 2'b00;
    logic [1:0]  en_w, err_w, busy_w, ss_w, sck_w, mosi_w;
    logic [11:0] a_w [2];
    logic [11:0] b_w [2];
    logic [11:0] c_w [2];

    adc_ad7928_reader u_dut0 (
        .clk(clk), .rst(rst), .sn_adc(sn[0]), .en_adc(en_w[0]),
        .adc_a(a_w[0]), .adc_b(b_w[0]), .adc_c(c_w[0]), .addr_err(err_w[0]),
        .busy(busy_w[0]), .spi_ss(ss_w[0]), .spi_sck(sck_w[0]),
        .spi_mosi(mosi_w[0]), .spi_miso(miso_r[0])
    );

    adc_ad7928_reader #(.CLK_DIV(8'd1), .CS_GAP(8'd1)) u_dut1 (
        .clk(clk), .rst(rst), .sn_adc(sn[1]), .en_adc(en_w[1]),
        .adc_a(a_w[1]), .adc_b(b_w[1]), .adc_c(c_w[1]), .addr_err(err_w[1]),
        .busy(busy_w[1]), .spi_ss(ss_w[1]), .spi_sck(sck_w[1]),
        .spi_mosi(mosi_w[1]), .spi_miso(miso_r[1])
    );

    // ADC model configuration (written by the stimulus only)
    int          bad_frame [2];
    logic [11:0] da [2];
    logic [11:0] db [2];
    logic [11:0] dc [2];

    // Monitor / model state
    int          cyc = 0;
    logic        pss  [2];
    logic        psck [2];
    int          nfr [2], nfall [2], lowc [2], highc [2];
    logic [15:0] cmd [2];
    logic [15:0] rw  [2];
    logic [2:0]  pch [2];
    logic [15:0] mw   [2][4];
    int          lows [2][4];
    int          gaps [2][4];
    int          t0 [2], en_last [2], en_tot [2], en_seq [2], act [2];

    // ADC model and pin monitor, evaluated mid-cycle on both instances
    always @(negedge clk) begin : p_mon
        logic [2:0]  ad;
        logic [11:0] dd;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                pss[i] = 1'b1; psck[i] = 1'b1;
                nfr[i] = 0; nfall[i] = 0; lowc[i] = 0; highc[i] = 0;
                miso_r[i] = 1'b0;
            end else begin
                if (sn[i] && !busy_w[i]) begin
                    t0[i] = cyc; en_seq[i] = 0; nfr[i] = 0;
                    for (int j = 0; j < 4; j++) begin
                        mw[i][j] = 16'h0; lows[i][j] = 0; gaps[i][j] = 0;
                    end
                end
                if (en_w[i]) begin
                    en_tot[i]++; en_seq[i]++; en_last[i] = cyc;
                end
                if (ss_w[i] !== pss[i] || sck_w[i] !== psck[i]) act[i]++;
                if (pss[i] && !ss_w[i]) begin
                    if (nfr[i] > 0 && nfr[i] <= 3) gaps[i][nfr[i]-1] = highc[i];
                    lowc[i] = 0; nfall[i] = 0; cmd[i] = 16'h0;
                    if (nfr[i] == 0) begin
                        rw[i] = 16'h7ABC;
                    end else begin
                        dd = (pch[i] == 3'd0) ? da[i] :
                             (pch[i] == 3'd1) ? db[i] :
                             (pch[i] == 3'd2) ? dc[i] : 12'h000;
                        ad = (nfr[i] == bad_frame[i]) ? 3'd5 : pch[i];
                        rw[i] = {1'b0, ad, dd};
                    end
                    miso_r[i] = rw[i][15];
                end
                if (!ss_w[i] && psck[i] && !sck_w[i]) begin
                    if (nfall[i] < 16) miso_r[i] = rw[i][15-nfall[i]];
                    nfall[i]++;
                end
                if (!ss_w[i] && !psck[i] && sck_w[i]) cmd[i] = {cmd[i][14:0], mosi_w[i]};
                if (!pss[i] && ss_w[i]) begin
                    if (nfr[i] < 4) begin
                        mw[i][nfr[i]]   = cmd[i];
                        lows[i][nfr[i]] = lowc[i];
                    end
                    pch[i] = cmd[i][12:10];
                    nfr[i]++;
                    highc[i] = 0;
                end
                if (!ss_w[i]) lowc[i]++; else highc[i]++;
                pss[i] = ss_w[i]; psck[i] = sck_w[i];
            end
        end
        cyc++;
    end

    int n_chk = 0;
    int n_err = 0;
    int cur_case = 0;

    task automatic chk(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
        n_chk++;
        if (act_v !== exp_v) begin
            n_err++;
            $display("FAIL %s (case %0d): got %0h, expected %0h", nm, cur_case, act_v, exp_v);
        end
    endtask

    task automatic pulse(input int i);
        sn[i] = 1'b1;
        @(posedge clk); #1;
        sn[i] = 1'b0;
    endtask

    task automatic wait_en(input int i, input int budget);
        int s;
        bit seen;
        s = en_tot[i];
        seen = 1'b0;
        for (int n = 0; n < budget && !seen; n++) begin
            @(posedge clk);
            if (en_tot[i] != s) seen = 1'b1;
        end
        #1;
        chk("en_timeout", {31'd0, seen}, 32'd1);
    endtask

    typedef struct {
        int          inst;
        int          bad;
        logic [11:0] da, db, dc;
        logic [11:0] ea, eb, ec;
        logic        eerr;
        int          elat;
        int          elow;
        int          egap;
    } vec_t;

    vec_t        vt [6];
    logic [15:0] exp_mosi [4];

    task automatic run_vec(input vec_t v);
        bad_frame[v.inst] = v.bad;
        da[v.inst] = v.da; db[v.inst] = v.db; dc[v.inst] = v.dc;
        pulse(v.inst);
        wait_en(v.inst, 400);
        repeat (4) @(posedge clk);
        #1;
        chk("en_pulses", en_seq[v.inst], 1);
        chk("latency", en_last[v.inst] - t0[v.inst], v.elat);
        chk("adc_a", a_w[v.inst], v.ea);
        chk("adc_b", b_w[v.inst], v.eb);
        chk("adc_c", c_w[v.inst], v.ec);
        chk("addr_err", err_w[v.inst], v.eerr);
        chk("busy_after", busy_w[v.inst], 0);
        for (int k = 0; k < 4; k++) begin
            chk("mosi_word", mw[v.inst][k], exp_mosi[k]);
            chk("ss_low", lows[v.inst][k], v.elow);
        end
        for (int k = 0; k < 3; k++) chk("ss_gap", gaps[v.inst][k], v.egap);
    endtask

    initial begin : p_stim
        int a0 [2];
        int t0a, et;
        exp_mosi[0] = 16'h8310; exp_mosi[1] = 16'h8710;
        exp_mosi[2] = 16'h8B10; exp_mosi[3] = 16'h8B10;
        //          inst bad  da      db      dc      ea      eb      ec    err  lat  low gap
        vt[0] = '{0, -1, 12'h123, 12'h456, 12'h789, 12'h123, 12'h456, 12'h789, 1'b0, 269, 65, 2};
        vt[1] = '{0,  2, 12'h123, 12'h456, 12'h789, 12'h123, 12'h456, 12'h789, 1'b1, 269, 65, 2};
        vt[2] = '{0, -1, 12'hABC, 12'h001, 12'hFFF, 12'hABC, 12'h001, 12'hFFF, 1'b0, 269, 65, 2};
        vt[3] = '{0,  3, 12'h800, 12'h7FF, 12'h055, 12'h800, 12'h7FF, 12'h055, 1'b1, 269, 65, 2};
        vt[4] = '{1, -1, 12'h123, 12'h456, 12'h789, 12'h123, 12'h456, 12'h789, 1'b0, 137, 33, 1};
        vt[5] = '{1,  1, 12'h3C3, 12'h0F0, 12'hA5A, 12'h3C3, 12'h0F0, 12'hA5A, 1'b1, 137, 33, 1};
        for (int i = 0; i < 2; i++) begin
            bad_frame[i] = -1; da[i] = 12'h0; db[i] = 12'h0; dc[i] = 12'h0;
            en_tot[i] = 0; en_seq[i] = 0; act[i] = 0; t0[i] = 0; en_last[i] = 0;
        end

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            cur_case = 100 + i;
            chk("rst_ss", ss_w[i], 1);
            chk("rst_sck", sck_w[i], 1);
            chk("rst_mosi", mosi_w[i], 0);
            chk("rst_en", en_w[i], 0);
            chk("rst_busy", busy_w[i], 0);
            chk("rst_err", err_w[i], 0);
            chk("rst_a", a_w[i], 0);
            chk("rst_b", b_w[i], 0);
            chk("rst_c", c_w[i], 0);
        end
        rst = 1'b0;
        for (int i = 0; i < 2; i++) a0[i] = act[i];
        repeat (50) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            cur_case = 100 + i;
            chk("idle_activity", act[i] - a0[i], 0);
        end

        // Table-driven sequences
        for (int v = 0; v < 6; v++) begin
            cur_case = v;
            run_vec(vt[v]);
        end

        // Requests while busy and in the DONE cycle are ignored
        cur_case = 200;
        bad_frame[0] = -1; da[0] = 12'h123; db[0] = 12'h456; dc[0] = 12'h789;
        pulse(0);
        t0a = t0[0];
        et  = en_tot[0];
        repeat (99) @(posedge clk);
        #1;
        pulse(0);
        repeat (168) @(posedge clk);
        #1;
        pulse(0);
        pulse(0);
        chk("busy_en_once", en_tot[0] - et, 1);
        chk("busy_lat", en_last[0] - t0a, 269);
        chk("restart_time", t0[0] - t0a, 270);
        wait_en(0, 400);
        repeat (2) @(posedge clk);
        #1;
        chk("restart_lat", en_last[0] - t0a, 539);
        chk("restart_a", a_w[0], 12'h123);
        chk("restart_c", c_w[0], 12'h789);

        // Reset during frame 2 shift
        cur_case = 300;
        pulse(0);
        repeat (150) @(posedge clk);
        #1;
        chk("pre_rst_ss", ss_w[0], 0);
        chk("pre_rst_frame", nfr[0], 2);
        rst = 1'b1;
        #1;
        chk("mid_rst_ss", ss_w[0], 1);
        chk("mid_rst_sck", sck_w[0], 1);
        chk("mid_rst_busy", busy_w[0], 0);
        chk("mid_rst_a", a_w[0], 0);
        chk("mid_rst_b", b_w[0], 0);
        chk("mid_rst_c", c_w[0], 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        et = en_tot[0];
        repeat (300) @(posedge clk);
        #1;
        chk("no_en_after_rst", en_tot[0] - et, 0);
        cur_case = 301;
        run_vec(vt[2]);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    // Absolute time limit so the run always terminates
    initial begin : p_watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
